apb_master_arbiter: RTL
=======================

# apb_master_arbiter

Round-robin APB requester arbiter and master sequencer that shares one APB slave (e.g. `APB_slave`) between `NUM_REQ` local requesters. It accepts one request at a time and drives the APB SETUP/ACCESS protocol. It also waits out slave wait states, enforces a wait-state timeout, and returns read data and error status to the requester that owned the transfer. It sits between on-chip requesters and the `paddr/pwdata/pwrite/psel/penable/pready/prdata/pslverr` bus.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `ADDR_WIDTH`, 8, APB address width
- `DATA_WIDTH`, 32, APB data width
- `TIMEOUT`, 16, maximum ACCESS-phase cycles before abort (≥2)

- `pclk`  in  1  clock; all logic on rising edge
- `presetn`  in  1  reset, synchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester request valid; held until accepted
- `req_ready`  out  NUM_REQ  per-requester accept, combinational, one-hot or zero
- `req_write`  in  NUM_REQ  per-requester direction (1 = write)
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse to owning requester
- `rsp_rdata`  out  DATA_WIDTH  read data for the completed transfer; 0 for writes and aborts
- `rsp_err`  out  1  completion error (pslverr or timeout), valid with `rsp_valid`
- `paddr`  out  ADDR_WIDTH  APB address
- `pwdata`  out  DATA_WIDTH  APB write data
- `pwrite`  out  1  APB direction
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `pready`  in  1  APB slave ready
- `prdata`  in  DATA_WIDTH  APB read data
- `pslverr`  in  1  APB slave error

## Operation
- FSM states:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- **IDLE**
  - If any `req_valid` is set, grant the first set requester found searching from `last_grant+1` modulo NUM_REQ.
  - Drive that requester's `req_ready` high combinationally. The handshake completes on this edge.
  - On the edge: latch addr/wdata/write into `paddr/pwdata/pwrite`, store the owner index, set `last_grant` to the owner, and go to SETUP.
- **SETUP**
  - Lasts exactly one cycle, then ACCESS unconditionally.
  - Clear the wait counter on entry to ACCESS.
- **ACCESS**
  - `pready`=1: go to IDLE, drop psel/penable, pulse `rsp_valid[owner]` for 1 cycle, and set `rsp_err`=pslverr.
  - `rsp_rdata`=prdata for a read and 0 for a write.
  - `pready`=0: increment the counter. When the counter reaches TIMEOUT-1 with `pready` still 0, abort: go to IDLE, drop psel/penable, set `rsp_valid[owner]`=1, `rsp_err`=1, `rsp_rdata`=0.
- `paddr/pwdata/pwrite` are stable from SETUP through the last ACCESS cycle and hold their value in IDLE.
- `req_ready` is 0 in SETUP and ACCESS, so there is never more than one outstanding transfer.
- `rsp_rdata/rsp_err` hold their last value when `rsp_valid`=0.
- Reset values:
  - State IDLE; `last_grant` = NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0.
- Reset mid-transfer: the next edge with `presetn`=0 forces IDLE, drops psel/penable, and discards the transfer. No `rsp_valid` is issued.
- Unused `pready`/`pslverr` outside ACCESS are ignored.

## Timing
- Request accepted in cycle N. SETUP is cycle N+1 and the first ACCESS cycle is N+2.
- Zero-wait transfer: `rsp_valid` in cycle N+3. The next request can be accepted in that same N+3 cycle, giving a sustained 3-cycle throughput per transfer.
- Each slave wait state adds 1 cycle.
- Timeout: ACCESS lasts at most TIMEOUT cycles, so `rsp_valid`/`rsp_err` appear at N+2+TIMEOUT.
- Simultaneous requests:
  - Exactly one grant per IDLE cycle.
  - Losers keep `req_valid` high and are served in rotation.
  - No requester waits more than NUM_REQ-1 transfers.
- `req_ready` depends only on state, `req_valid` and `last_grant`. It has no path from `pready`.

## Test plan
- **Single write:** req0 write addr 0x10, data 0xDEADBEEF, slave pready=1 immediately.
  - Required: psel at N+1, penable at N+2, paddr=0x10, pwdata=0xDEADBEEF, pwrite=1.
  - Required: `rsp_valid`=2'b01 at N+3, `rsp_err`=0, `rsp_rdata`=0.
- **Read with wait states:** req1 read addr 0x10, slave inserts 3 wait states, prdata=0xDEADBEEF.
  - Required: penable high for 4 cycles.
  - Required: `rsp_valid`=2'b10 with `rsp_rdata`=0xDEADBEEF at N+6.
- **Contention:** req0 and req1 both valid continuously for 4 transfers from reset.
  - Required: grant order 0,1,0,1 and `req_ready` never 2'b11.
- **Slave error:** read with pslverr=1 alongside pready.
  - Required: `rsp_err`=1 and `rsp_rdata`=prdata on the `rsp_valid` pulse.
- **Timeout:** pready held 0.
  - Required: exactly 16 ACCESS cycles, then psel=0, `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
- **Reset mid-ACCESS:** `presetn`=0 for 1 cycle during a wait state.
  - Required: next cycle psel=penable=0, no `rsp_valid`.
  - Required: after reset, req0 is granted first when both requesters are valid.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin requester arbiter driving one APB slave
module apb_master_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic                          pwrite,
  output logic                          psel,
  output logic                          penable,
  input  logic                          pready,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last_grant, owner, gnt_idx, cand;
  logic               gnt_found;
  logic [CNT_W-1:0]   wait_cnt;
  logic               done, abort;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    req_ready = '0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          state_nxt          = SETUP;
        end
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      wait_cnt   <= '0;
      paddr      <= '0;
      pwdata     <= '0;
      pwrite     <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (state == IDLE && gnt_found) begin
        paddr      <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        pwdata     <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        pwrite     <= req_write[gnt_idx];
        owner      <= gnt_idx;
        last_grant <= gnt_idx;
      end
      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !pready)
        wait_cnt <= wait_cnt + 1'b1;
      if (done) begin
        rsp_valid[owner] <= 1'b1;
        rsp_err          <= pslverr;
        rsp_rdata        <= pwrite ? '0 : prdata;
      end else if (abort) begin
        rsp_valid[owner] <= 1'b1;
        rsp_err          <= 1'b1;
        rsp_rdata        <= '0;
      end
    end
  end

endmodule
